io_port_endpoint: RTL and testbench
===================================

// Module: io_port_endpoint
// PURPOSE
//  Peripheral-side endpoint for one Octavo I/O read port and one I/O write port.
//  Terminates the CPU's EF/rden/wren port protocol in two small FIFOs:
//   - RX path: external valid/ready source -> CPU read port.
//   - TX path: CPU write port -> external valid/ready sink.
//  Instantiated once per port pair, outside the Scalar core.
// PARAMETERS
//  WORD_WIDTH  36  data word width; matches A/B_WORD_WIDTH of the attached port
//  DEPTH       4   entries per FIFO; power of two, >= 2
//  ADDR_WIDTH  2   log2(DEPTH)
// PORTS
//  clock       in   1           single clock
//  reset       in   1           synchronous, active-high
//  io_in       out  WORD_WIDTH  RX head word presented to CPU read port
//  io_in_EF    out  1           1 = RX FIFO empty; CPU must not read
//  io_rden     in   1           CPU read strobe; pops RX head
//  io_out      in   WORD_WIDTH  CPU write data
//  io_out_EF   out  1           1 = TX FIFO full; CPU must not write
//  io_wren     in   1           CPU write strobe; pushes io_out
//  src_data    in   WORD_WIDTH  external RX data
//  src_valid   in   1           external RX data valid
//  src_ready   out  1           RX FIFO can accept
//  snk_data    out  WORD_WIDTH  TX head word to external sink
//  snk_valid   out  1           TX FIFO non-empty
//  snk_ready   in   1           external sink accepts
//  err_clear   in   1           clear sticky errors (IO_ENDPOINT_ERR_EN only)
//  err_rx_underflow out 1       sticky: io_rden while io_in_EF=1
//  err_tx_overflow  out 1       sticky: io_wren while io_out_EF=1
// BEHAVIOUR
//  - Each FIFO has registers for storage, head ptr, tail ptr (ADDR_WIDTH bits), and count (0..DEPTH).
//  - Pointers wrap from DEPTH-1 to 0.
//  - Storage is not reset.
//  - Reset values:
//     - counts = 0, ptrs = 0.
//     - io_in_EF = 1, io_out_EF = 0.
//     - src_ready = 1, snk_valid = 0.
//     - io_in = 0, snk_data = 0, errors = 0.
//  - Reset asserted mid-operation discards all queued words on the next edge.
//  - Flags are decoded from the registered count only, never from same-cycle inputs:
//     - io_in_EF = (rx_count == 0); src_ready = (rx_count != DEPTH).
//     - io_out_EF = (tx_count == DEPTH); snk_valid = (tx_count != 0).
//  - Show-ahead output, gated to 0 when the FIFO is empty:
//     - io_in = mem_rx[head]; snk_data = mem_tx[head].
//  - Push and pop qualification:
//     - RX push = src_valid & src_ready.
//     - RX pop = io_rden & !io_in_EF.
//     - TX push = io_wren & !io_out_EF.
//     - TX pop = snk_valid & snk_ready.
//  - Push and pop in the same cycle: count unchanged, both pointers advance, order preserved.
//     - Full: push is blocked, so a pop alone decrements.
//     - Empty: pop is ignored, so a push alone increments.
//  - Latency:
//     - src push at edge N -> io_in_EF = 0 and io_in valid after edge N.
//     - io_rden at edge N -> head advances at edge N.
//     - The TX path has the same latency.
//  - Unqualified io_rden / io_wren (empty / full) changes no FIFO state.
// CONFIGURATION
//  IO_ENDPOINT_ERR_EN defined:
//   - The error registers set on the cycle after an unqualified strobe and stay set.
//   - err_clear clears them next edge.
//   - If a new error and err_clear occur together, the flag stays set.
//  IO_ENDPOINT_ERR_EN undefined:
//   - Error outputs are tied to 0 and err_clear is ignored.
//   - No error registers are built.
// TESTING
//  1. Reset with any input activity -> io_in_EF=1, io_out_EF=0, src_ready=1, snk_valid=0, io_in=0, snk_data=0.
//  2. src push 36'hA5 -> next cycle io_in_EF=0, io_in=36'hA5; io_rden 1 cycle -> io_in_EF=1, io_in=0.
//  3. src pushes 1,2,3,4 with no reads -> src_ready=0 after 4th and 5 is held off.
//     - One io_rden -> src_ready=1, 5 accepted; reads return 2,3,4,5.
//  4. snk_ready=0, io_wren 10..13 -> io_out_EF=1; then snk_ready=1 -> snk_data 10,11,12,13 in order, snk_valid=0 after.
//  5. rx_count=2, src push + io_rden every cycle for 8 cycles -> count stays 2; order intact across pointer wrap.
//  6. io_rden on empty (ERR_EN) -> err_rx_underflow=1 sticky, FIFO unchanged; err_clear -> 0.
//     - Without ERR_EN the error outputs stay 0.
//     - Reset mid-fill (2 words queued) -> io_in_EF=1 next cycle.

Source files
------------

// File: rtl/io_port_endpoint.sv
// Octavo I/O port endpoint: RX FIFO (valid/ready source -> CPU read port) and
// TX FIFO (CPU write port -> valid/ready sink). Optional sticky error flags: IO_ENDPOINT_ERR_EN.
module io_port_endpoint #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [WORD_WIDTH-1:0] io_in,
    output logic                  io_in_EF,
    input  logic                  io_rden,
    input  logic [WORD_WIDTH-1:0] io_out,
    output logic                  io_out_EF,
    input  logic                  io_wren,
    input  logic [WORD_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [WORD_WIDTH-1:0] snk_data,
    output logic                  snk_valid,
    input  logic                  snk_ready,
    input  logic                  err_clear,
    output logic                  err_rx_underflow,
    output logic                  err_tx_overflow
);

    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE  = ADDR_WIDTH'(32'd1);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE  = (ADDR_WIDTH+1)'(32'd1);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [WORD_WIDTH-1:0] r_rx_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rx_head;
    logic [ADDR_WIDTH-1:0] r_rx_tail;
    logic [ADDR_WIDTH:0]   r_rx_count;

    logic [WORD_WIDTH-1:0] r_tx_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_tx_head;
    logic [ADDR_WIDTH-1:0] r_tx_tail;
    logic [ADDR_WIDTH:0]   r_tx_count;

    logic w_rx_push;
    logic w_rx_pop;
    logic w_tx_push;
    logic w_tx_pop;

    // Flags depend only on registered counts so the CPU never sees a same-cycle loop.
    assign io_in_EF  = (r_rx_count == {(ADDR_WIDTH+1){1'b0}});
    assign src_ready = (r_rx_count != LP_CNT_FULL);
    assign io_out_EF = (r_tx_count == LP_CNT_FULL);
    assign snk_valid = (r_tx_count != {(ADDR_WIDTH+1){1'b0}});

    assign io_in    = io_in_EF  ? {WORD_WIDTH{1'b0}} : r_rx_mem[r_rx_head];
    assign snk_data = snk_valid ? r_tx_mem[r_tx_head] : {WORD_WIDTH{1'b0}};

    assign w_rx_push = src_valid & src_ready;
    assign w_rx_pop  = io_rden & ~io_in_EF;
    assign w_tx_push = io_wren & ~io_out_EF;
    assign w_tx_pop  = snk_valid & snk_ready;

    // RX storage write; contents are never reset.
    always_ff @(posedge clock) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_tail] <= src_data;
        end
    end

    // TX storage write; contents are never reset.
    always_ff @(posedge clock) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_tail] <= io_out;
        end
    end

    // RX pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_head  <= {ADDR_WIDTH{1'b0}};
            r_rx_tail  <= {ADDR_WIDTH{1'b0}};
            r_rx_count <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (w_rx_push) begin
                r_rx_tail <= r_rx_tail + LP_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_head <= r_rx_head + LP_PTR_ONE;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + LP_CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - LP_CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // TX pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_head  <= {ADDR_WIDTH{1'b0}};
            r_tx_tail  <= {ADDR_WIDTH{1'b0}};
            r_tx_count <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (w_tx_push) begin
                r_tx_tail <= r_tx_tail + LP_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_head <= r_tx_head + LP_PTR_ONE;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + LP_CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - LP_CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

`ifdef IO_ENDPOINT_ERR_EN
    logic r_err_rx;
    logic r_err_tx;

    // Sticky protocol errors; a new error wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_rx <= 1'b0;
            r_err_tx <= 1'b0;
        end else begin
            r_err_rx <= (io_rden & io_in_EF)  | (r_err_rx & ~err_clear);
            r_err_tx <= (io_wren & io_out_EF) | (r_err_tx & ~err_clear);
        end
    end

    assign err_rx_underflow = r_err_rx;
    assign err_tx_overflow  = r_err_tx;
`else
    logic w_unused_err_clear;
    assign w_unused_err_clear = err_clear;
    assign err_rx_underflow   = 1'b0;
    assign err_tx_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_endpoint.sv
// Self-checking bench for io_port_endpoint: queue-based reference model,
// per-cycle compare process, directed scenarios plus randomized traffic.
module tb_io_port_endpoint;

    localparam int WW    = 36;
    localparam int DEPTH = 4;
`ifdef IO_ENDPOINT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [WW-1:0] io_in;
    logic          io_in_EF;
    logic          io_rden;
    logic [WW-1:0] io_out;
    logic          io_out_EF;
    logic          io_wren;
    logic [WW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [WW-1:0] snk_data;
    logic          snk_valid;
    logic          snk_ready;
    logic          err_clear;
    logic          err_rx_underflow;
    logic          err_tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [WW-1:0] rx_q[$];
    logic [WW-1:0] tx_q[$];
    bit            m_err_rx = 1'b0;
    bit            m_err_tx = 1'b0;

    io_port_endpoint #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
        .clock(clock), .reset(reset),
        .io_in(io_in), .io_in_EF(io_in_EF), .io_rden(io_rden),
        .io_out(io_out), .io_out_EF(io_out_EF), .io_wren(io_wren),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .err_clear(err_clear),
        .err_rx_underflow(err_rx_underflow), .err_tx_overflow(err_tx_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO semantics on queues, evaluated from pre-edge occupancy.
    always @(posedge clock) begin
        if (reset) begin
            rx_q.delete();
            tx_q.delete();
            m_err_rx = 1'b0;
            m_err_tx = 1'b0;
        end else begin
            bit rx_push, rx_pop, tx_push, tx_pop, rx_bad, tx_bad;
            rx_push = src_valid && (rx_q.size() < DEPTH);
            rx_pop  = io_rden && (rx_q.size() > 0);
            rx_bad  = io_rden && (rx_q.size() == 0);
            tx_push = io_wren && (tx_q.size() < DEPTH);
            tx_pop  = snk_ready && (tx_q.size() > 0);
            tx_bad  = io_wren && (tx_q.size() == DEPTH);
            if (rx_pop)  void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(src_data);
            if (tx_pop)  void'(tx_q.pop_front());
            if (tx_push) tx_q.push_back(io_out);
            if (ERR_EN) begin
                m_err_rx = rx_bad || (m_err_rx && !err_clear);
                m_err_tx = tx_bad || (m_err_tx && !err_clear);
            end
        end
    end

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clock) begin
        logic [WW-1:0] e_in, e_snk;
        e_in  = (rx_q.size() == 0) ? '0 : rx_q[0];
        e_snk = (tx_q.size() == 0) ? '0 : tx_q[0];
        chk("io_in_EF",  {63'd0, io_in_EF},  {63'd0, rx_q.size() == 0});
        chk("src_ready", {63'd0, src_ready}, {63'd0, rx_q.size() != DEPTH});
        chk("io_out_EF", {63'd0, io_out_EF}, {63'd0, tx_q.size() == DEPTH});
        chk("snk_valid", {63'd0, snk_valid}, {63'd0, tx_q.size() != 0});
        chk("io_in",     {28'd0, io_in},     {28'd0, e_in});
        chk("snk_data",  {28'd0, snk_data},  {28'd0, e_snk});
        chk("err_rx",    {63'd0, err_rx_underflow}, {63'd0, m_err_rx});
        chk("err_tx",    {63'd0, err_tx_overflow},  {63'd0, m_err_tx});
    end

    task automatic idle();
        io_rden = 1'b0; io_wren = 1'b0; src_valid = 1'b0;
        snk_ready = 1'b0; err_clear = 1'b0; reset = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [63:0] rnd;
        // 1: reset with activity on every input
        reset = 1'b1; io_rden = 1'b1; io_wren = 1'b1; src_valid = 1'b1;
        snk_ready = 1'b1; err_clear = 1'b1;
        src_data = 36'h123456789; io_out = 36'hFEDCBA987;
        cyc(3);
        chk("rst io_in_EF",  {63'd0, io_in_EF},  64'd1);
        chk("rst io_out_EF", {63'd0, io_out_EF}, 64'd0);
        chk("rst src_ready", {63'd0, src_ready}, 64'd1);
        chk("rst snk_valid", {63'd0, snk_valid}, 64'd0);
        chk("rst io_in",     {28'd0, io_in},     64'd0);
        chk("rst snk_data",  {28'd0, snk_data},  64'd0);
        idle();

        // 2: single push then pop
        src_data = 36'hA5; src_valid = 1'b1; cyc(1); src_valid = 1'b0;
        chk("t2 EF after push", {63'd0, io_in_EF}, 64'd0);
        chk("t2 io_in",         {28'd0, io_in},    64'hA5);
        io_rden = 1'b1; cyc(1); io_rden = 1'b0;
        chk("t2 EF after pop",  {63'd0, io_in_EF}, 64'd1);
        chk("t2 io_in gated",   {28'd0, io_in},    64'd0);

        // 3: fill RX, hold off a fifth word, then drain
        for (int i = 1; i <= 4; i++) begin
            src_data = WW'(i); src_valid = 1'b1; cyc(1);
        end
        chk("t3 full src_ready", {63'd0, src_ready}, 64'd0);
        src_data = 36'd5; cyc(2);
        chk("t3 head held", {28'd0, io_in}, 64'd1);
        io_rden = 1'b1; cyc(1); io_rden = 1'b0;
        chk("t3 ready after pop", {63'd0, src_ready}, 64'd1);
        cyc(1); src_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            chk("t3 read order", {28'd0, io_in}, 64'(i));
            io_rden = 1'b1; cyc(1);
        end
        io_rden = 1'b0;
        chk("t3 drained", {63'd0, io_in_EF}, 64'd1);

        // 4: fill TX with sink stalled, then drain in order
        snk_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            io_out = WW'(i); io_wren = 1'b1; cyc(1);
        end
        io_wren = 1'b0;
        chk("t4 io_out_EF", {63'd0, io_out_EF}, 64'd1);
        snk_ready = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            chk("t4 snk_data", {28'd0, snk_data}, 64'(i));
            cyc(1);
        end
        chk("t4 snk_valid off", {63'd0, snk_valid}, 64'd0);
        snk_ready = 1'b0;

        // 5: steady state at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            src_data = WW'(100 + i); src_valid = 1'b1; cyc(1);
        end
        for (int i = 0; i < 8; i++) begin
            chk("t5 order", {28'd0, io_in}, 64'(100 + i));
            src_data = WW'(102 + i); io_rden = 1'b1; cyc(1);
        end
        src_valid = 1'b0;
        chk("t5 head", {28'd0, io_in}, 64'd108);
        cyc(1);
        chk("t5 count2 a", {63'd0, io_in_EF}, 64'd0);
        cyc(1); io_rden = 1'b0;
        chk("t5 count2 b", {63'd0, io_in_EF}, 64'd1);

        // 6: unqualified strobes, sticky errors, clear priority
        io_rden = 1'b1; cyc(1); io_rden = 1'b0;
        chk("t6 underflow", {63'd0, err_rx_underflow}, {63'd0, ERR_EN});
        cyc(2);
        chk("t6 sticky", {63'd0, err_rx_underflow}, {63'd0, ERR_EN});
        chk("t6 rx unchanged", {63'd0, io_in_EF}, 64'd1);
        err_clear = 1'b1; cyc(1); err_clear = 1'b0;
        chk("t6 cleared", {63'd0, err_rx_underflow}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            io_out = WW'(20 + i); io_wren = 1'b1; cyc(1);
        end
        chk("t6 overflow", {63'd0, err_tx_overflow}, {63'd0, ERR_EN});
        err_clear = 1'b1; cyc(1); err_clear = 1'b0; io_wren = 1'b0;
        chk("t6 set beats clear", {63'd0, err_tx_overflow}, {63'd0, ERR_EN});
        chk("t6 tx head kept", {28'd0, snk_data}, 64'd20);
        err_clear = 1'b1; cyc(1); err_clear = 1'b0;
        chk("t6 tx cleared", {63'd0, err_tx_overflow}, 64'd0);

        // reset mid-fill discards queued words
        for (int i = 0; i < 2; i++) begin
            src_data = WW'(30 + i); src_valid = 1'b1; cyc(1);
        end
        src_valid = 1'b0; reset = 1'b1; cyc(1); reset = 1'b0;
        chk("midrst io_in_EF", {63'd0, io_in_EF}, 64'd1);
        chk("midrst snk_valid", {63'd0, snk_valid}, 64'd0);

        // randomized traffic checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            rnd = {$urandom(), $urandom()};
            src_data  = rnd[35:0];
            rnd = {$urandom(), $urandom()};
            io_out    = rnd[35:0];
            src_valid = ($urandom_range(0, 3) != 0);
            io_rden   = ($urandom_range(0, 2) == 0);
            io_wren   = ($urandom_range(0, 2) != 0);
            snk_ready = ($urandom_range(0, 1) == 0);
            err_clear = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 127) == 0);
            cyc(1);
        end
        idle();
        cyc(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
